// File: rtl/fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arbiter
// Description : Two-port req/ack arbiter and sequencer in front of a single
//               FIFO instance. Grants one requester at a time (round-robin
//               when both ask), issues one-cycle push/pop commands to the
//               FIFO, tracks occupancy so overflow/underflow are never
//               issued, and returns pop data on the winner's rdata port.
// Ports       : i_clk, i_reset           clock, synchronous active-high reset
//               i_req_*/i_op_*/i_wdata_* requester A/B request, op (0 push,
//                                        1 pop) and push data
//               o_ack_*/o_err_*/o_rdata_* completion pulse, reject flag, pop data
//               o_fifo_enable/cmd/data   command port to the FIFO
//               i_fifo_data/i_fifo_done  response from the FIFO
//               o_count/o_full/o_empty   occupancy
//               o_proto_err              sticky: FIFO failed to signal done
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_req_a,
    input  logic                       i_req_b,
    input  logic                       i_op_a,
    input  logic                       i_op_b,
    input  logic [WIDTH-1:0]           i_wdata_a,
    input  logic [WIDTH-1:0]           i_wdata_b,
    output logic                       o_ack_a,
    output logic                       o_ack_b,
    output logic                       o_err_a,
    output logic                       o_err_b,
    output logic [WIDTH-1:0]           o_rdata_a,
    output logic [WIDTH-1:0]           o_rdata_b,
    output logic                       o_fifo_enable,
    output logic [1:0]                 o_fifo_cmd,
    output logic [WIDTH-1:0]           o_fifo_data,
    input  logic [WIDTH-1:0]           i_fifo_data,
    input  logic                       i_fifo_done,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_proto_err
);

    localparam int         CW        = $clog2(DEPTH) + 1;
    localparam logic [1:0] C_CMD_NONE = 2'd0;
    localparam logic [1:0] C_CMD_PUSH = 2'd1;
    localparam logic [1:0] C_CMD_POP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_win_b;      // granted port: 0 = A, 1 = B
    logic             r_op;         // granted operation: 0 = push, 1 = pop
    logic             r_rej;        // granted request was rejected
    logic             r_prio_b;     // round-robin: 1 = B wins a tie
    logic             r_proto_err;
    logic [WIDTH-1:0] r_fifo_data;
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic [CW-1:0]    r_count;

    logic             w_req_any;
    logic             w_pick_b;
    logic             w_op;
    logic [WIDTH-1:0] w_wdata;
    logic             w_full;
    logic             w_empty;
    logic             w_rej;

    assign w_req_any = i_req_a | i_req_b;
    // B wins when it is the only requester, or on a tie when it holds priority.
    assign w_pick_b  = i_req_b & (~i_req_a | r_prio_b);
    assign w_op      = w_pick_b ? i_op_b    : i_op_a;
    assign w_wdata   = w_pick_b ? i_wdata_b : i_wdata_a;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // Rejection is decided at grant time from the registered count, so the
    // FIFO never sees a push when full or a pop when empty.
    assign w_rej     = w_op ? w_empty : w_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_win_b     <= 1'b0;
            r_op        <= 1'b0;
            r_rej       <= 1'b0;
            r_prio_b    <= 1'b0;
            r_proto_err <= 1'b0;
            r_fifo_data <= '0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_win_b <= w_pick_b;
                        r_op    <= w_op;
                        r_rej   <= w_rej;
                        if (!w_rej) begin
                            r_fifo_data <= w_wdata;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (!i_fifo_done) begin
                        r_proto_err <= 1'b1;
                    end
                    if (r_op) begin
                        if (r_win_b) begin
                            r_rdata_b <= i_fifo_data;
                        end else begin
                            r_rdata_a <= i_fifo_data;
                        end
                        r_count <= r_count - CW'(1);
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_RESP: begin
                    // Hand the tie-break to the port that did not just win.
                    r_prio_b <= ~r_win_b;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next  = r_state;
        o_fifo_enable = 1'b0;
        o_fifo_cmd    = C_CMD_NONE;
        o_ack_a       = 1'b0;
        o_ack_b       = 1'b0;
        o_err_a       = 1'b0;
        o_err_b       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_next = w_rej ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_fifo_enable = 1'b1;
                o_fifo_cmd    = r_op ? C_CMD_POP : C_CMD_PUSH;
                w_state_next  = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                o_ack_a      = ~r_win_b;
                o_ack_b      = r_win_b;
                o_err_a      = ~r_win_b & r_rej;
                o_err_b      = r_win_b & r_rej;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_fifo_data = r_fifo_data;
    assign o_rdata_a   = r_rdata_a;
    assign o_rdata_b   = r_rdata_b;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_arbiter
// Description : Self-checking bench for fifo_arbiter with a small behavioural
//               FIFO attached. A transaction-level reference model (queue of
//               stored data plus cycles-since-grant) is compared against the
//               DUT every cycle; directed tasks add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             req_a, req_b, op_a, op_b;
    logic [WIDTH-1:0] wdata_a, wdata_b;
    logic             ack_a, ack_b, err_a, err_b;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic             fen;
    logic [1:0]       fcmd;
    logic [WIDTH-1:0] fdata_to;
    logic [WIDTH-1:0] fdata_from;
    logic             fdone;
    logic [CW-1:0]    count;
    logic             full, empty, proto;

    int errors = 0;
    int checks = 0;

    fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_a(req_a), .i_req_b(req_b), .i_op_a(op_a), .i_op_b(op_b),
        .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
        .o_ack_a(ack_a), .o_ack_b(ack_b), .o_err_a(err_a), .o_err_b(err_b),
        .o_rdata_a(rdata_a), .o_rdata_b(rdata_b),
        .o_fifo_enable(fen), .o_fifo_cmd(fcmd), .o_fifo_data(fdata_to),
        .i_fifo_data(fdata_from), .i_fifo_done(fdone),
        .o_count(count), .o_full(full), .o_empty(empty), .o_proto_err(proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: acts on the enabled command, reports done next cycle.
    logic [WIDTH-1:0] fmem [DEPTH];
    int               fhead, ftail;
    logic             drop_done;

    always @(posedge clk) begin
        if (rst) begin
            fdone      <= 1'b0;
            fdata_from <= '0;
            fhead      <= 0;
            ftail      <= 0;
        end else begin
            fdone <= fen && !drop_done;
            if (fen && fcmd == 2'd1) begin
                fmem[ftail] <= fdata_to;
                ftail       <= (ftail + 1) % DEPTH;
            end else if (fen && fcmd == 2'd2) begin
                fdata_from <= fmem[fhead];
                fhead      <= (fhead + 1) % DEPTH;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since the grant (0 = no transaction).
    int               m_age;
    bit               m_win_b, m_op, m_rej, m_prio_b, m_proto, m_done_seen;
    logic [WIDTH-1:0] m_data, m_fdata, m_rd_a, m_rd_b;
    logic [WIDTH-1:0] m_q [$];

    task automatic model_step();
        if (rst) begin
            m_age = 0; m_win_b = 0; m_op = 0; m_rej = 0; m_prio_b = 0; m_proto = 0;
            m_done_seen = 0; m_data = '0; m_fdata = '0; m_rd_a = '0; m_rd_b = '0;
            m_q.delete();
        end else begin
            case (m_age)
                0: if (req_a || req_b) begin
                    m_win_b = req_b && (!req_a || m_prio_b);
                    m_op    = m_win_b ? op_b : op_a;
                    m_data  = m_win_b ? wdata_b : wdata_a;
                    m_rej   = m_op ? (m_q.size() == 0) : (m_q.size() == DEPTH);
                    if (m_rej) begin
                        m_age = 3;
                    end else begin
                        m_fdata = m_data;
                        m_age   = 1;
                    end
                end
                1: begin
                    m_age       = 2;
                    m_done_seen = fdone;
                end
                2: begin
                    if (!m_done_seen) m_proto = 1;
                    if (m_op) begin
                        if (m_win_b) m_rd_b = m_q.pop_front();
                        else         m_rd_a = m_q.pop_front();
                    end else begin
                        m_q.push_back(m_data);
                    end
                    m_age = 3;
                end
                default: begin
                    m_prio_b = !m_win_b;
                    m_age    = 0;
                end
            endcase
        end
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
        check("fifo_enable", 32'(fen), 32'(m_age == 1));
        check("fifo_cmd", 32'(fcmd), (m_age == 1) ? (m_op ? 32'd2 : 32'd1) : 32'd0);
        check("fifo_data", 32'(fdata_to), 32'(m_fdata));
        check("ack_a", 32'(ack_a), 32'(m_age == 3 && !m_win_b));
        check("ack_b", 32'(ack_b), 32'(m_age == 3 && m_win_b));
        check("err_a", 32'(err_a), 32'(m_age == 3 && !m_win_b && m_rej));
        check("err_b", 32'(err_b), 32'(m_age == 3 && m_win_b && m_rej));
        check("rdata_a", 32'(rdata_a), 32'(m_rd_a));
        check("rdata_b", 32'(rdata_b), 32'(m_rd_b));
        check("count", 32'(count), 32'(m_q.size()));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("proto_err", 32'(proto), 32'(m_proto));
    end

    // One transaction from one port; checks latency and the FIFO strobe at t+1.
    task automatic txn(input bit pb, input bit op, input logic [WIDTH-1:0] d,
                       input int exp_lat, output logic [WIDTH-1:0] rd, output bit er);
        int n;
        bit got;
        @(negedge clk);
        if (pb) begin req_b = 1; op_b = op; wdata_b = d; end
        else    begin req_a = 1; op_a = op; wdata_a = d; end
        n = 0; got = 0; rd = '0; er = 0;
        while (n < 20 && !got) begin
            @(posedge clk); #1; n++;
            if (n == 1) check("strobe_t1", 32'(fen), 32'(exp_lat == 3));
            if (pb ? ack_b : ack_a) begin
                got = 1;
                rd  = pb ? rdata_b : rdata_a;
                er  = pb ? err_b : err_a;
            end
        end
        if (!got) check("ack_timeout", 32'(0), 32'(1));
        else      check("latency", 32'(n), 32'(exp_lat));
        @(negedge clk);
        req_a = 0; req_b = 0;
    endtask

    logic [WIDTH-1:0] rd;
    bit               er;

    initial begin
        rst = 1; req_a = 0; req_b = 0; op_a = 0; op_b = 0;
        wdata_a = '0; wdata_b = '0; drop_done = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_proto", 32'(proto), 32'd0);

        // A pushes three values, B pops them back in order.
        txn(0, 0, 8'h11, 3, rd, er);
        txn(0, 0, 8'h22, 3, rd, er);
        txn(0, 0, 8'h33, 3, rd, er);
        check("count_after_push3", 32'(count), 32'd3);
        txn(1, 1, 8'h00, 3, rd, er); check("pop1", 32'(rd), 32'h11);
        txn(1, 1, 8'h00, 3, rd, er); check("pop2", 32'(rd), 32'h22);
        txn(1, 1, 8'h00, 3, rd, er); check("pop3", 32'(rd), 32'h33);
        check("count_after_pop3", 32'(count), 32'd0);
        check("empty_after_pop3", 32'(empty), 32'd1);

        // Pop when empty is rejected one cycle after the grant.
        txn(1, 1, 8'h00, 1, rd, er);
        check("pop_empty_err", 32'(er), 32'd1);
        check("pop_empty_count", 32'(count), 32'd0);

        // Fill to DEPTH, overflow rejected, pop returns oldest.
        txn(0, 0, 8'h41, 3, rd, er);
        txn(0, 0, 8'h42, 3, rd, er);
        txn(0, 0, 8'h43, 3, rd, er);
        txn(0, 0, 8'h44, 3, rd, er);
        check("full_at_depth", 32'(full), 32'd1);
        txn(0, 0, 8'h45, 1, rd, er);
        check("push_full_err", 32'(er), 32'd1);
        txn(1, 1, 8'h00, 3, rd, er);
        check("pop_after_full", 32'(rd), 32'h41);
        check("full_dropped", 32'(full), 32'd0);

        // Missing done still completes but sets the sticky flag.
        drop_done = 1;
        txn(0, 0, 8'h55, 3, rd, er);
        drop_done = 0;
        check("proto_set", 32'(proto), 32'd1);
        txn(1, 1, 8'h00, 3, rd, er);
        check("pop_after_proto", 32'(rd), 32'h42);
        check("proto_sticky", 32'(proto), 32'd1);

        // Reset during CAPTURE of a push aborts it without an ack.
        begin
            int n;
            @(negedge clk);
            req_a = 1; op_a = 0; wdata_a = 8'h66;
            n = 0;
            while (n < 20 && !fen) begin @(posedge clk); #1; n++; end
            check("reset_test_issue_seen", 32'(fen), 32'd1);
            @(posedge clk);
            @(negedge clk);
            rst = 1; req_a = 0;
            @(posedge clk); #1;
            check("abort_no_ack", 32'(ack_a), 32'd0);
            check("abort_count", 32'(count), 32'd0);
            check("abort_empty", 32'(empty), 32'd1);
            check("abort_proto", 32'(proto), 32'd0);
            check("abort_rdata_b", 32'(rdata_b), 32'd0);
            @(negedge clk);
            rst = 0;
        end
        txn(1, 1, 8'h00, 1, rd, er);
        check("pop_after_reset_err", 32'(er), 32'd1);

        // Both ports requesting continuously: strict A,B alternation from reset.
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        begin
            int k;
            int cyc;
            req_a = 1; op_a = 0; wdata_a = 8'h70;
            req_b = 1; op_b = 1; wdata_b = 8'h00;
            k = 0; cyc = 0;
            while (k < 8 && cyc < 100) begin
                @(posedge clk); #1; cyc++;
                if (ack_a || ack_b) begin
                    check("grant_order", 32'(ack_b), 32'(k % 2));
                    check("alt_no_err", 32'(err_a | err_b), 32'd0);
                    if (ack_b) check("alt_pop_data", 32'(rdata_b), 32'(8'h70 + k / 2));
                    k++;
                    if (ack_a) begin
                        @(negedge clk);
                        wdata_a = wdata_a + 8'd1;
                    end
                end
            end
            if (k < 8) check("alt_timeout", 32'(k), 32'd8);
            @(negedge clk);
            req_a = 0; req_b = 0;
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
